// File: rtl/fetch_exec_sequencer.sv
// Control sequencer for a small 8051-style core: fetches one or two ROM bytes,
// decodes the opcode class, fires one cycle of datapath strobes and services interrupts.
module fetch_exec_sequencer (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [7:0] opcode_i,
   input  logic       data_vld_i,
   input  logic       int_i,
   input  logic       int_ack_i,
   output logic       rom_en_o,
   output logic       ir_load_high_o,
   output logic       ir_load_low_o,
   output logic       pc_inc_o,
   output logic       pc_inc_offset_o,
   output logic       acc_load_o,
   output logic       alu_en_o,
   output logic       ram_rd_en_reg_o,
   output logic       ram_rd_en_data_o,
   output logic       ram_wr_en_reg_o,
   output logic       ram_wr_en_data_o,
   output logic       int_vec_o,
   output logic       pop_1_stack_o,
   output logic       pop_2_stack_o,
   output logic       instr_done_o,
   output logic       illegal_o
);

   typedef enum logic [2:0] {
      FETCH1, DECODE, FETCH2, EXEC, POP2, CHECK, INT_ENTRY
   } state_e;

   typedef enum logic [3:0] {
      CL_NOP, CL_MOV_A_RN, CL_MOV_RN_A, CL_RETI, CL_MOV_A_IMM,
      CL_ADD_A_IMM, CL_MOV_A_DIR, CL_MOV_DIR_A, CL_SJMP, CL_ILLEGAL
   } opClass_e;

   state_e   state_q, state_d;
   opClass_e opClass_q, opClass_d;
   opClass_e decodedClass;
   logic     intPending_q, intPending_d;
   logic     inIsr_q, inIsr_d;
   logic     postReset_q;
   logic     twoByte;

   always_comb begin
      decodedClass = CL_ILLEGAL;
      casez (opcode_i)
         8'h00:       decodedClass = CL_NOP;
         8'b1110_1???: decodedClass = CL_MOV_A_RN;
         8'b1111_1???: decodedClass = CL_MOV_RN_A;
         8'h32:       decodedClass = CL_RETI;
         8'h74:       decodedClass = CL_MOV_A_IMM;
         8'h24:       decodedClass = CL_ADD_A_IMM;
         8'hE5:       decodedClass = CL_MOV_A_DIR;
         8'hF5:       decodedClass = CL_MOV_DIR_A;
         8'h80:       decodedClass = CL_SJMP;
         default:     decodedClass = CL_ILLEGAL;
      endcase
   end

   assign twoByte = (decodedClass == CL_MOV_A_IMM) || (decodedClass == CL_ADD_A_IMM) ||
                    (decodedClass == CL_MOV_A_DIR) || (decodedClass == CL_MOV_DIR_A) ||
                    (decodedClass == CL_SJMP);

   // The first FETCH1 cycle after reset keeps rom_en up but ignores data_vld,
   // so nothing but rom_en can toggle until the ROM has seen a clean request.
   always_comb begin
      state_d      = state_q;
      opClass_d    = opClass_q;
      inIsr_d      = inIsr_q;
      intPending_d = intPending_q;
      case (state_q)
         FETCH1:    if (data_vld_i && !postReset_q) state_d = DECODE;
         DECODE: begin
            if (decodedClass == CL_ILLEGAL) begin
               opClass_d = CL_NOP;
               state_d   = CHECK;
            end else begin
               opClass_d = decodedClass;
               state_d   = twoByte ? FETCH2 : EXEC;
            end
         end
         FETCH2:    if (data_vld_i) state_d = EXEC;
         EXEC:      state_d = (opClass_q == CL_RETI) ? POP2 : CHECK;
         POP2: begin
            inIsr_d = 1'b0;
            state_d = CHECK;
         end
         CHECK:     state_d = (intPending_q && !inIsr_q) ? INT_ENTRY : FETCH1;
         INT_ENTRY: begin
            if (int_ack_i) begin
               inIsr_d      = 1'b1;
               intPending_d = 1'b0;
               state_d      = FETCH1;
            end
         end
         default:   state_d = FETCH1;
      endcase
      if (int_i) intPending_d = 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= FETCH1;
         opClass_q    <= CL_NOP;
         inIsr_q      <= 1'b0;
         intPending_q <= 1'b0;
         postReset_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         opClass_q    <= opClass_d;
         inIsr_q      <= inIsr_d;
         intPending_q <= intPending_d;
         postReset_q  <= 1'b0;
      end
   end

   always_comb begin
      rom_en_o         = 1'b0;
      ir_load_high_o   = 1'b0;
      ir_load_low_o    = 1'b0;
      pc_inc_o         = 1'b0;
      pc_inc_offset_o  = 1'b0;
      acc_load_o       = 1'b0;
      alu_en_o         = 1'b0;
      ram_rd_en_reg_o  = 1'b0;
      ram_rd_en_data_o = 1'b0;
      ram_wr_en_reg_o  = 1'b0;
      ram_wr_en_data_o = 1'b0;
      int_vec_o        = 1'b0;
      pop_1_stack_o    = 1'b0;
      pop_2_stack_o    = 1'b0;
      instr_done_o     = 1'b0;
      illegal_o        = 1'b0;
      if (!reset_i) begin
         case (state_q)
            FETCH1: begin
               rom_en_o       = 1'b1;
               ir_load_high_o = data_vld_i && !postReset_q;
               pc_inc_o       = data_vld_i && !postReset_q;
            end
            DECODE:    illegal_o = (decodedClass == CL_ILLEGAL);
            FETCH2: begin
               rom_en_o      = 1'b1;
               ir_load_low_o = data_vld_i;
               pc_inc_o      = data_vld_i;
            end
            EXEC: begin
               case (opClass_q)
                  CL_MOV_A_IMM, CL_ADD_A_IMM: begin
                     alu_en_o   = 1'b1;
                     acc_load_o = 1'b1;
                  end
                  CL_MOV_A_DIR: begin
                     ram_rd_en_data_o = 1'b1;
                     acc_load_o       = 1'b1;
                  end
                  CL_MOV_DIR_A: ram_wr_en_data_o = 1'b1;
                  CL_MOV_A_RN: begin
                     ram_rd_en_reg_o = 1'b1;
                     acc_load_o      = 1'b1;
                  end
                  CL_MOV_RN_A: ram_wr_en_reg_o = 1'b1;
                  CL_SJMP:     pc_inc_offset_o = 1'b1;
                  CL_RETI:     pop_1_stack_o   = 1'b1;
                  default:     ;
               endcase
            end
            POP2:      pop_2_stack_o = 1'b1;
            CHECK:     instr_done_o  = 1'b1;
            INT_ENTRY: int_vec_o     = 1'b1;
            default:   ;
         endcase
      end
   end

endmodule
